// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency synchronous data-memory port
// between the M-stage requester and the bridge/debug (D) requester.
module dm_port_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [1:0]  m_size,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_stall,
  output logic        m_done,
  output logic [31:0] m_rdata,
  output logic        m_exc,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_exc,
  output logic        mem_en,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic        gnt_d_q;
  logic        last_d_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt_q;
  logic        m_done_q, d_done_q, m_exc_q, d_exc_q;
  logic [31:0] m_rdata_q, d_rdata_q;

  logic        pick_d;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_misal;

  // D wins only when M is idle or M was the last port served.
  assign pick_d    = d_req & (~m_req | ~last_d_q);
  assign sel_we    = pick_d ? d_we    : m_we;
  assign sel_size  = pick_d ? d_size  : m_size;
  assign sel_addr  = pick_d ? d_addr  : m_addr;
  assign sel_wdata = pick_d ? d_wdata : m_wdata;
  assign sel_misal = (sel_size == 2'b11)
                   | ((sel_size == 2'b00) & (sel_addr[1:0] != 2'b00))
                   | ((sel_size == 2'b10) & sel_addr[0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_d_q   <= 1'b0;
      last_d_q  <= 1'b1;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      m_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      m_exc_q   <= 1'b0;
      d_exc_q   <= 1'b0;
      m_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      m_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m_req | d_req) begin
            gnt_d_q <= pick_d;
            we_q    <= sel_we;
            size_q  <= sel_size;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            if (sel_misal) begin
              state_q <= DONE;
              if (pick_d) begin
                d_done_q  <= 1'b1;
                d_exc_q   <= 1'b1;
                d_rdata_q <= '0;
              end else begin
                m_done_q  <= 1'b1;
                m_exc_q   <= 1'b1;
                m_rdata_q <= '0;
              end
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= 4'(LAT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            if (gnt_d_q) begin
              d_done_q  <= 1'b1;
              d_exc_q   <= 1'b0;
              d_rdata_q <= mem_rdata;
            end else begin
              m_done_q  <= 1'b1;
              m_exc_q   <= 1'b0;
              m_rdata_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          last_d_q <= gnt_d_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory strobe fields are decoded from the latched request, live only in ISSUE.
  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = '0;
    mem_addr  = '0;
    if (state_q == ISSUE) begin
      mem_addr = {addr_q[31:2], 2'b00};
      case (size_q)
        2'b00: begin
          mem_be    = 4'b1111;
          mem_wdata = wdata_q;
        end
        2'b10: begin
          mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_be    = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{wdata_q[7:0]}};
        end
      endcase
      if (!we_q) mem_be = 4'b0000;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign m_stall   = m_req & ~m_done_q;
  assign m_done    = m_done_q;
  assign m_rdata   = m_rdata_q;
  assign m_exc     = m_exc_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_exc     = d_exc_q;
  assign dbg_state = state_q;

endmodule
